xgmm_sched: RTL and testbench
=============================

# xgmm_sched

Memory-port scheduler on the XGMM side of the graphics register interface. It shares the single-port pattern RAM (4096x16) and attribute RAM (8192x16) between video fetch reads and CPU writes drained from the pattern and attribute FIFOs. Video reads always win and have a fixed one-cycle issue latency. FIFO words are written in otherwise idle cycles at base address plus a running burst offset.

## Interface
Parameters:
- STARVE_LIMIT, 64: consecutive blocked cycles before a starvation flag is raised (range 1..255).

Ports:
- clk_sys  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- v_p_req  in  1  video pattern read request this cycle
- v_p_addr  in  12  video pattern read address
- v_a_req  in  1  video attribute read request this cycle
- v_a_addr  in  13  video attribute read address
- p_empty, a_empty  in  1  FIFO empty flags; show-ahead FIFOs, data valid while not empty
- p_data, a_data  in  16  FIFO head words
- par  in  12  pattern write base address
- aar  in  13  attribute write base address
- p_pop, a_pop  out  1  FIFO pop strobes, registered
- pm_en, pm_we  out  1  pattern RAM enable and write enable, registered
- pm_addr  out  12  pattern RAM address
- pm_wdata  out  16  pattern RAM write data
- am_en, am_we  out  1  attribute RAM enable and write enable, registered
- am_addr  out  13  attribute RAM address
- am_wdata  out  16  attribute RAM write data
- p_starve, a_starve  out  1  starvation flags

## Operation
- Pattern (p) and attribute (a) channels are independent and identical except for widths. The description below uses p.
- Each cycle the block makes a decision, which is registered onto the RAM port for the next cycle.
- Priority 1: v_p_req=1 gives next cycle pm_en=1, pm_we=0, pm_addr=v_p_addr. No write is issued.
- Priority 2: if v_p_req=0, FSM=IDLE and p_empty=0, the block issues a write. Next cycle: pm_en=1, pm_we=1, pm_addr=par+p_off (mod 2^12), pm_wdata=p_data, p_pop=1. p_off then increments and FSM goes to POP.
- Otherwise: next cycle pm_en=0, pm_we=0, p_pop=0. pm_addr and pm_wdata hold their values.
- FSM states:
  - IDLE: eligible to write.
  - POP: the pop is in flight. p_empty is stale, so no write decision is made. Always returns to IDLE after one cycle.
  - Maximum drain rate is one word per 2 cycles.
- A video request arriving while FSM=POP is served normally. The write already on the port is not disturbed.
- Burst offset p_off (12 bits, a_off 13 bits):
  - Clears to 0 when FSM=IDLE and p_empty=1.
  - Otherwise increments by 1 per issued write and wraps at 2^width.
- Starvation counter (8 bits):
  - Increments, saturating at STARVE_LIMIT, in cycles where FSM=IDLE, p_empty=0 and v_p_req=1.
  - Clears when a write is issued.
  - p_starve=1 while the counter equals STARVE_LIMIT; it drops together with the clear.
- par and aar are sampled only in the decision cycle. A change mid-burst affects only subsequent words.

## Timing
- Reset (rst_n=0, asynchronous): all outputs 0, FSM=IDLE, offsets 0, starvation counters 0.
- Video read: request at cycle N gives the RAM port at N+1, every time, regardless of write activity.
- Write: decided at N; pm_we=1 and p_pop=1 together at N+1. The FIFO advances at the N+1 edge, and the next decision is possible at N+2.
- Reset asserted mid-operation: an in-flight pop is dropped immediately. The FIFO resets on the same reset, so no word is lost or duplicated relative to the FIFO.
- Both channels may write, or read, in the same cycle. There is no cross-channel interaction.

## Test plan
- Reset release, then 3 words pushed to the pattern FIFO (par=0x100), v_p_req=0 → writes to 0x100, 0x101, 0x102 on cycles 1, 3 and 5 after the first non-empty cycle. p_pop pulses 3 times and p_off returns to 0.
- v_p_req held at 1 for 10 cycles with the pattern FIFO non-empty → every port cycle is a read at v_p_addr with no writes. The first write occurs the cycle after v_p_req drops.
- STARVE_LIMIT=4, a_empty=0, v_a_req=1 for 6 cycles → a_starve rises after the 4th blocked cycle. It clears on the cycle the write is issued after v_a_req drops.
- par=0xFFE with 4 queued words → addresses 0xFFE, 0xFFF, 0x000, 0x001.
- v_p_req rises in the POP cycle of a write → the write completes unchanged and the read appears on the following cycle.
- rst_n pulsed low while p_pop=1 → all outputs 0 asynchronously. After release, FSM=IDLE and p_off=0.

Source files
------------

// File: rtl/xgmm_sched_if.sv
// xgmm_sched_if: video/FIFO/RAM port bundle of the XGMM memory scheduler.
// slave = scheduler side, master = environment side.
interface xgmm_sched_if;
    logic        v_p_req;
    logic [11:0] v_p_addr;
    logic        v_a_req;
    logic [12:0] v_a_addr;
    logic        p_empty;
    logic        a_empty;
    logic [15:0] p_data;
    logic [15:0] a_data;
    logic [11:0] par;
    logic [12:0] aar;
    logic        p_pop;
    logic        a_pop;
    logic        pm_en;
    logic        pm_we;
    logic [11:0] pm_addr;
    logic [15:0] pm_wdata;
    logic        am_en;
    logic        am_we;
    logic [12:0] am_addr;
    logic [15:0] am_wdata;
    logic        p_starve;
    logic        a_starve;

    modport slave (
        input  v_p_req, v_p_addr, v_a_req, v_a_addr,
        input  p_empty, a_empty, p_data, a_data, par, aar,
        output p_pop, a_pop,
        output pm_en, pm_we, pm_addr, pm_wdata,
        output am_en, am_we, am_addr, am_wdata,
        output p_starve, a_starve
    );

    modport master (
        output v_p_req, v_p_addr, v_a_req, v_a_addr,
        output p_empty, a_empty, p_data, a_data, par, aar,
        input  p_pop, a_pop,
        input  pm_en, pm_we, pm_addr, pm_wdata,
        input  am_en, am_we, am_addr, am_wdata,
        input  p_starve, a_starve
    );
endinterface

// File: rtl/xgmm_sched.sv
// xgmm_sched: shares pattern/attribute RAM ports between video reads
// (always first, one-cycle latency) and FIFO-drained CPU writes.
module xgmm_sched_ch #(
    parameter int AW           = 12,
    parameter int STARVE_LIMIT = 64
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          vreq_i,
    input  logic [AW-1:0] vaddr_i,
    input  logic          empty_i,
    input  logic [15:0]   data_i,
    input  logic [AW-1:0] base_i,
    output logic          pop_o,
    output logic          en_o,
    output logic          we_o,
    output logic [AW-1:0] addr_o,
    output logic [15:0]   wdata_o,
    output logic          starve_o
);
    typedef enum logic {IDLE, POP} state_e;

    localparam logic [7:0]    LIM = 8'(STARVE_LIMIT);
    localparam logic [AW-1:0] ONE = AW'(1);

    state_e        state_q, state_d;
    logic [AW-1:0] off_q, off_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          pop_q, en_q, we_q;
    logic [AW-1:0] addr_q;
    logic [15:0]   wdata_q;
    logic          wr, blk;

    // Write only when video is quiet and the FIFO head is fresh.
    always_comb begin
        wr      = !vreq_i && state_q == IDLE && !empty_i;
        blk     = vreq_i && state_q == IDLE && !empty_i;
        state_d = wr ? POP : IDLE;
        off_d   = off_q;
        if (state_q == IDLE && empty_i)
            off_d = '0;
        else if (wr)
            off_d = off_q + ONE;
        cnt_d = cnt_q;
        if (wr)
            cnt_d = '0;
        else if (blk && cnt_q != LIM)
            cnt_d = cnt_q + 8'd1;
    end

    // FSM, burst offset, starvation count and registered RAM port.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            off_q   <= '0;
            cnt_q   <= '0;
            pop_q   <= 1'b0;
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
            pop_q   <= wr;
            en_q    <= vreq_i | wr;
            we_q    <= wr;
            if (vreq_i) begin
                addr_q <= vaddr_i;
            end else if (wr) begin
                addr_q  <= base_i + off_q;
                wdata_q <= data_i;
            end
        end
    end

    assign pop_o    = pop_q;
    assign en_o     = en_q;
    assign we_o     = we_q;
    assign addr_o   = addr_q;
    assign wdata_o  = wdata_q;
    assign starve_o = cnt_q == LIM;
endmodule

module xgmm_sched #(
    parameter int STARVE_LIMIT = 64
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    xgmm_sched_if.slave bus
);
    xgmm_sched_ch #(.AW(12), .STARVE_LIMIT(STARVE_LIMIT)) u_p (
        .clk_i    (clk_sys),
        .rst_ni   (rst_n),
        .vreq_i   (bus.v_p_req),
        .vaddr_i  (bus.v_p_addr),
        .empty_i  (bus.p_empty),
        .data_i   (bus.p_data),
        .base_i   (bus.par),
        .pop_o    (bus.p_pop),
        .en_o     (bus.pm_en),
        .we_o     (bus.pm_we),
        .addr_o   (bus.pm_addr),
        .wdata_o  (bus.pm_wdata),
        .starve_o (bus.p_starve)
    );

    xgmm_sched_ch #(.AW(13), .STARVE_LIMIT(STARVE_LIMIT)) u_a (
        .clk_i    (clk_sys),
        .rst_ni   (rst_n),
        .vreq_i   (bus.v_a_req),
        .vaddr_i  (bus.v_a_addr),
        .empty_i  (bus.a_empty),
        .data_i   (bus.a_data),
        .base_i   (bus.aar),
        .pop_o    (bus.a_pop),
        .en_o     (bus.am_en),
        .we_o     (bus.am_we),
        .addr_o   (bus.am_addr),
        .wdata_o  (bus.am_wdata),
        .starve_o (bus.a_starve)
    );
endmodule

// File: tb/tb_xgmm_sched.sv
// tb_xgmm_sched: directed bench with show-ahead FIFO models and a
// per-channel queue of expected RAM port cycles.
module tb_xgmm_sched;
    logic clk_sys = 1'b0;
    logic rst_n   = 1'b0;

    always #5 clk_sys = ~clk_sys;

    xgmm_sched_if bus ();

    xgmm_sched #(.STARVE_LIMIT(4)) dut (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    typedef struct {
        int          cyc;
        logic        we;
        logic [12:0] addr;
        logic [15:0] data;
    } exp_t;

    exp_t        pexp[$];
    exp_t        aexp[$];
    logic [15:0] pq[$];
    logic [15:0] aq[$];
    int          cyc   = 0;
    int          npass = 0;
    int          ntot  = 0;
    int          nfail = 0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic void refresh();
        bus.p_empty = pq.size() == 0;
        bus.p_data  = pq.size() != 0 ? pq[0] : 16'h0;
        bus.a_empty = aq.size() == 0;
        bus.a_data  = aq.size() != 0 ? aq[0] : 16'h0;
    endfunction

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
            refresh();
        end
    endtask

    task automatic ep(int c, logic we, logic [12:0] a, logic [15:0] d);
        pexp.push_back('{c, we, a, d});
    endtask

    task automatic ea(int c, logic we, logic [12:0] a, logic [15:0] d);
        aexp.push_back('{c, we, a, d});
    endtask

    always @(posedge clk_sys) cyc <= cyc + 1;

    // FIFO models: advance on a registered pop, clear on reset.
    always @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            pq.delete();
            aq.delete();
        end else begin
            if (bus.p_pop && pq.size() != 0) void'(pq.pop_front());
            if (bus.a_pop && aq.size() != 0) void'(aq.pop_front());
        end
    end

    // Scoreboard: every enabled port cycle must match the queue head.
    always @(negedge clk_sys) begin
        exp_t e;
        if (rst_n) begin
            if (bus.pm_en) begin
                chk("p_pending", 64'(pexp.size() > 0), 64'd1);
                if (pexp.size() > 0) begin
                    e = pexp.pop_front();
                    chk("p_cyc", 64'(cyc), 64'(e.cyc));
                    chk("p_we", 64'(bus.pm_we), 64'(e.we));
                    chk("p_pop", 64'(bus.p_pop), 64'(e.we));
                    chk("p_addr", 64'(bus.pm_addr), 64'(e.addr));
                    if (e.we) chk("p_wdata", 64'(bus.pm_wdata), 64'(e.data));
                end
            end else begin
                chk("p_idle", 64'({bus.p_pop, bus.pm_we}), 64'd0);
            end
            if (bus.am_en) begin
                chk("a_pending", 64'(aexp.size() > 0), 64'd1);
                if (aexp.size() > 0) begin
                    e = aexp.pop_front();
                    chk("a_cyc", 64'(cyc), 64'(e.cyc));
                    chk("a_we", 64'(bus.am_we), 64'(e.we));
                    chk("a_pop", 64'(bus.a_pop), 64'(e.we));
                    chk("a_addr", 64'(bus.am_addr), 64'(e.addr));
                    if (e.we) chk("a_wdata", 64'(bus.am_wdata), 64'(e.data));
                end
            end else begin
                chk("a_idle", 64'({bus.a_pop, bus.am_we}), 64'd0);
            end
        end
    end

    task automatic chk_zero(string tag);
        chk({tag, "_p"}, 64'({bus.p_pop, bus.pm_en, bus.pm_we, bus.pm_addr,
                              bus.pm_wdata, bus.p_starve}), 64'd0);
        chk({tag, "_a"}, 64'({bus.a_pop, bus.am_en, bus.am_we, bus.am_addr,
                              bus.am_wdata, bus.a_starve}), 64'd0);
    endtask

    initial begin
        int c;
        bus.v_p_req  = 1'b0;
        bus.v_p_addr = '0;
        bus.v_a_req  = 1'b0;
        bus.v_a_addr = '0;
        bus.par      = '0;
        bus.aar      = '0;
        refresh();
        step(2);
        chk_zero("reset");
        rst_n = 1'b1;
        step(1);

        // Three-word burst from par=0x100.
        bus.par = 12'h100;
        pq.push_back(16'hA001);
        pq.push_back(16'hA002);
        pq.push_back(16'hA003);
        refresh();
        c = cyc;
        ep(c + 1, 1'b1, 13'h100, 16'hA001);
        ep(c + 3, 1'b1, 13'h101, 16'hA002);
        ep(c + 5, 1'b1, 13'h102, 16'hA003);
        step(8);
        chk("t1_drain", 64'(pexp.size()), 64'd0);
        pq.push_back(16'hA004);
        refresh();
        ep(cyc + 1, 1'b1, 13'h100, 16'hA004);
        step(3);
        chk("t1_off0", 64'(pexp.size()), 64'd0);

        // Video holds the pattern port for 10 cycles.
        bus.par = 12'h300;
        pq.push_back(16'hB001);
        bus.v_p_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.v_p_addr = 12'(12'h200 + i);
            ep(cyc + 1, 1'b0, 13'(12'h200 + i), 16'h0);
            step(1);
        end
        chk("t2_starve", 64'(bus.p_starve), 64'd1);
        bus.v_p_req = 1'b0;
        ep(cyc + 1, 1'b1, 13'h300, 16'hB001);
        step(1);
        chk("t2_starve_clr", 64'(bus.p_starve), 64'd0);
        step(3);
        chk("t2_drain", 64'(pexp.size()), 64'd0);

        // Attribute starvation with limit 4.
        bus.aar = 13'h0AA;
        aq.push_back(16'hC001);
        bus.v_a_req = 1'b1;
        refresh();
        for (int i = 0; i < 6; i++) begin
            bus.v_a_addr = 13'(13'h1000 + i);
            ea(cyc + 1, 1'b0, 13'(13'h1000 + i), 16'h0);
            chk("t3_starve", 64'(bus.a_starve), 64'(i >= 4));
            step(1);
        end
        chk("t3_starve_hold", 64'(bus.a_starve), 64'd1);
        bus.v_a_req = 1'b0;
        ea(cyc + 1, 1'b1, 13'h0AA, 16'hC001);
        step(1);
        chk("t3_starve_clr", 64'(bus.a_starve), 64'd0);
        chk("t3_we", 64'(bus.am_we), 64'd1);
        step(3);
        chk("t3_drain", 64'(aexp.size()), 64'd0);

        // Address wrap on both channels at once.
        bus.par = 12'hFFE;
        bus.aar = 13'h1FFF;
        pq.push_back(16'hD001);
        pq.push_back(16'hD002);
        pq.push_back(16'hD003);
        pq.push_back(16'hD004);
        aq.push_back(16'hE001);
        aq.push_back(16'hE002);
        refresh();
        c = cyc;
        ep(c + 1, 1'b1, 13'hFFE, 16'hD001);
        ep(c + 3, 1'b1, 13'hFFF, 16'hD002);
        ep(c + 5, 1'b1, 13'h000, 16'hD003);
        ep(c + 7, 1'b1, 13'h001, 16'hD004);
        ea(c + 1, 1'b1, 13'h1FFF, 16'hE001);
        ea(c + 3, 1'b1, 13'h0000, 16'hE002);
        step(10);
        chk("t4_pdrain", 64'(pexp.size()), 64'd0);
        chk("t4_adrain", 64'(aexp.size()), 64'd0);

        // Video request arriving in the POP cycle.
        bus.par = 12'h050;
        pq.push_back(16'hF001);
        pq.push_back(16'hF002);
        refresh();
        c = cyc;
        ep(c + 1, 1'b1, 13'h050, 16'hF001);
        step(1);
        bus.v_p_req  = 1'b1;
        bus.v_p_addr = 12'h777;
        ep(c + 2, 1'b0, 13'h777, 16'h0);
        step(1);
        bus.v_p_req = 1'b0;
        ep(c + 3, 1'b1, 13'h051, 16'hF002);
        step(4);
        chk("t5_drain", 64'(pexp.size()), 64'd0);

        // Reset pulse while a pop is on the port.
        bus.par = 12'h010;
        pq.push_back(16'h1111);
        pq.push_back(16'h2222);
        refresh();
        ep(cyc + 1, 1'b1, 13'h010, 16'h1111);
        step(1);
        chk("t6_pop", 64'(bus.p_pop), 64'd1);
        @(negedge clk_sys);
        #1;
        rst_n = 1'b0;
        #1;
        chk_zero("t6_async");
        step(2);
        rst_n = 1'b1;
        pq.push_back(16'h3333);
        refresh();
        ep(cyc + 1, 1'b1, 13'h010, 16'h3333);
        step(3);
        chk("t6_drain", 64'(pexp.size()), 64'd0);
        chk("t6_adrain", 64'(aexp.size()), 64'd0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
